cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Operand width is split into BLK-bit groups. Each group uses full p/g lookahead internally, and one group resolves per pipeline stage, with the group carry registered between stages. It sits in the datapath as a streaming arithmetic unit behind a valid/ready handshake on both sides, and adds subtract mode and overflow flags.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of BLK.
BLK, 4, lookahead group width; pipeline depth NSTG = WIDTH/BLK (derived, not overridable).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0: A+B+cin; 1: A-B (cin ignored)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: every stage valid bit = 0, all pipeline data = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. Reset wins over any concurrent handshake. Beats in flight at reset are discarded and never appear at the output.
- Operand conditioning at capture: b_eff = sub ? ~b : b; c_in_eff = sub ? 1 : cin.
- Stage k (0..NSTG-1) computes bits [k*BLK +: BLK]:
  - p = a^b_eff, g = a&b_eff.
  - Full lookahead carries inside the group from the registered carry of stage k-1 (c_in_eff for stage 0). No ripple inside a group.
  - Group sum bits and group carry-out are registered.
- Unprocessed upper operand slices and finished lower sum slices travel with the beat, so each beat carries a self-contained state.
- Latency: a beat accepted at edge T (in_valid & in_ready) presents out_valid = 1 after edge T+NSTG, provided no stall occurs.
- Throughput: one beat per cycle.
- Flags, set in the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Flow control:
  - Global advance enable en = !out_valid | out_ready.
  - in_ready = en (combinational from out_valid/out_ready; never from in_valid).
  - When en = 0, all stage registers, valid bits and outputs hold.
  - When en = 1, every stage shifts one place and stage 0 loads the input beat; if in_valid = 0 it loads a bubble (valid 0).
  - Bubbles propagate and do not block later beats, beyond the stall rule above.
- Output stability: while out_valid = 1 and out_ready = 0, sum/cout/ovf/out_valid stay constant.
- Output is a registered beat. With out_valid = 0, sum/cout/ovf hold their previous values; their content is not checked while out_valid = 0.
- Ordering: results leave in acceptance order. No drop, no duplication.
- Simultaneous input accept and output consume in one cycle is legal and required for full throughput.
- sub and cin are sampled only at acceptance and travel with the beat; changes while in_ready = 0 have no effect.
- Wrap-around: sum is modulo 2^WIDTH; carry past MSB appears only on cout.
- Degenerate config BLK = WIDTH: NSTG = 1, latency 1 cycle.
- Parameter legality: WIDTH % BLK != 0 or BLK < 1 is an elaboration error (generate-time check).

Test Plan:
1. WIDTH=16, BLK=4, add: a=0x00FF, b=0x0001, cin=0, accepted at cycle 0 -> out_valid at cycle 4, sum=0x0100, cout=0, ovf=0. Exercises cross-group carry.
2. Full carry chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
3. Subtract, covering both results:
   - a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
4. Streaming with backpressure:
   - 20 back-to-back random beats with out_ready toggling, including 3 consecutive low cycles.
   - Required: in_ready = 0 exactly when out_valid & !out_ready; outputs stable during stall; all 20 results match a reference model, in order, with no gaps when out_ready is held high.
5. Bubbles: in_valid pattern 1,0,1,1,0 with out_ready = 1 -> out_valid pattern is the same sequence delayed 4 cycles, with matching results.
6. Reset mid-flight: 3 beats in flight, assert rst for 1 cycle -> out_valid = 0 and sum/cout/ovf = 0 after that edge. None of the 3 beats ever emerges. A beat accepted on the cycle after reset returns normally 4 cycles later.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. The operand is split into
// BLK-bit groups. Each group is resolved with full p/g lookahead in its own
// pipeline stage, and the group carry is registered between stages. The
// unprocessed upper operand bits and the finished lower sum bits travel with
// each beat, so every stage holds a self-contained beat.
//
// Pipeline layout (NSTG = WIDTH/BLK):
//   capture regs (index 0)  : operands conditioned for add/sub
//   stage k (k=0..NSTG-1)   : resolves bits [k*BLK +: BLK] from regs[k]
//                             and writes regs[k+1], or the output regs when
//                             k is the last stage
//   Latency from acceptance to out_valid is NSTG cycles.
//
// Handshake: a beat moves on a side when valid and ready are both high at
// the rising clock edge. The whole pipe advances together on
// en = !out_valid | out_ready. in_ready equals en and never depends on
// in_valid. When en is low, every register holds. An empty capture slot
// (in_valid low while en is high) is a bubble that flows through the pipe.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry-in, used in add mode only
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode 1 means no borrow)
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / BLK;

    generate
        if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_bad_param
            $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
        end
    endgenerate

    // Per-beat state entering each stage.
    logic             r_v [0:NSTG-1];
    logic [WIDTH-1:0] r_a [0:NSTG-1];
    logic [WIDTH-1:0] r_b [0:NSTG-1];   // b after add/sub conditioning
    logic [WIDTH-1:0] r_s [0:NSTG-1];   // sum bits finished so far
    logic             r_c [0:NSTG-1];   // carry into this stage's group

    // Output beat registers.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Combinational result of each stage.
    logic [WIDTH-1:0] w_s_nxt [0:NSTG-1];
    logic             w_c_nxt [0:NSTG-1];
    logic             w_c_msb;          // carry into bit WIDTH-1
    logic             w_en;

    // AND of p[lo..hi]; an empty range (lo > hi) yields 1.
    function automatic logic grp_and(input logic [BLK-1:0] p,
                                     input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int m = 0; m < BLK; m++) begin
            if (m >= lo && m <= hi) begin
                r = r & p[m];
            end
        end
        return r;
    endfunction

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Group lookahead. Every internal carry is a flat sum of products of
    // the group's generate/propagate terms and the incoming group carry:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0]
    // so no carry inside a group depends on another internal carry.
    always_comb begin
        logic [BLK-1:0] p;
        logic [BLK-1:0] g;
        logic [BLK:0]   c;
        p       = '0;
        g       = '0;
        c       = '0;
        w_c_msb = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            w_s_nxt[k] = r_s[k];
            w_c_nxt[k] = 1'b0;
        end
        for (int k = 0; k < NSTG; k++) begin
            p    = r_a[k][k*BLK +: BLK] ^ r_b[k][k*BLK +: BLK];
            g    = r_a[k][k*BLK +: BLK] & r_b[k][k*BLK +: BLK];
            c    = '0;
            c[0] = r_c[k];
            for (int i = 0; i < BLK; i++) begin
                c[i+1] = r_c[k] & grp_and(p, 0, i);
                for (int j = 0; j <= i; j++) begin
                    c[i+1] = c[i+1] | (g[j] & grp_and(p, j + 1, i));
                end
            end
            w_s_nxt[k][k*BLK +: BLK] = p ^ c[BLK-1:0];
            w_c_nxt[k]               = c[BLK];
            if (k == NSTG - 1) begin
                w_c_msb = c[BLK-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            // Capture: subtraction is a + ~b + 1, so cin is ignored in sub.
            r_v[0] <= in_valid;
            r_a[0] <= a;
            r_b[0] <= sub ? ~b : b;
            r_c[0] <= sub ? 1'b1 : cin;
            r_s[0] <= '0;
            for (int k = 1; k < NSTG; k++) begin
                r_v[k] <= r_v[k-1];
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_s[k] <= w_s_nxt[k-1];
                r_c[k] <= w_c_nxt[k-1];
            end
            r_out_valid <= r_v[NSTG-1];
            // Result data only changes for a real beat; a bubble leaves
            // the previous result on sum/cout/ovf.
            if (r_v[NSTG-1]) begin
                r_sum  <= w_s_nxt[NSTG-1];
                r_cout <= w_c_nxt[NSTG-1];
                r_ovf  <= w_c_nxt[NSTG-1] ^ w_c_msb;
            end
        end
    end

endmodule
